// File: rtl/bcg_line_fetcher.sv
// bcg_line_fetcher: display-side scanline fetcher.
// Walks the tile map for one background scanline and reads, per tile, the
// texture number, both texture-row bytes and the palette nibble through the
// shared VRAM read port. It streams 6-bit colour indices
// {palette, pixel} through a front/back pair of 8-pixel buffers.
module bcg_line_fetcher #(
   parameter int TILES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        line_start,
   input  logic [7:0]  line_y,
   output logic        rd_req,
   output logic [12:0] rd_addr,
   input  logic        rd_gnt,
   input  logic [7:0]  rd_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [5:0]  pix_col,
   output logic        busy,
   output logic        line_done
);

   localparam int         PIX_TOTAL = 8 * TILES;
   localparam logic [5:0] LAST_TX   = 6'(TILES - 1);
   localparam logic [9:0] LAST_PIX  = 10'(PIX_TOTAL - 1);

   typedef enum logic [2:0] {
      IDLE,
      MAP,
      TEX0,
      TEX1,
      PAL,
      LOAD
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  tx_q, tx_d;
   logic [4:0]  ty_q, ty_d;
   logic [2:0]  yl_q, yl_d;
   logic [7:0]  tex_q, tex_d;
   logic [7:0]  tex0_q, tex0_d;
   logic [7:0]  tex1_q, tex1_d;
   logic [3:0]  pal_q, pal_d;
   logic        pend_q, pend_d;

   logic [15:0] front_px_q, front_px_d;
   logic [3:0]  front_pal_q, front_pal_d;
   logic [3:0]  front_cnt_q, front_cnt_d;
   logic [15:0] back_px_q, back_px_d;
   logic [3:0]  back_pal_q, back_pal_d;
   logic        back_full_q, back_full_d;
   logic [9:0]  pix_cnt_q, pix_cnt_d;
   logic        busy_q, busy_d;
   logic        line_done_q, line_done_d;

   logic        load_en;
   logic [15:0] load_px;
   logic [3:0]  load_pal;
   logic [3:0]  pal_nib;
   logic        tile_advance;
   logic        accept;

   assign pix_valid = (front_cnt_q != 4'd0);
   assign pix_col   = {front_pal_q, front_px_q[15:14]};
   assign busy      = busy_q;
   assign line_done = line_done_q;
   assign accept    = pix_valid & pix_ready;
   assign pal_nib   = ty_q[0] ? rd_data[3:0] : rd_data[7:4];

   // Fetch FSM: issue one read per state, capture its data the following cycle, then hand the finished tile to the back buffer.
   always_comb begin
      state_d      = state_q;
      tx_d         = tx_q;
      ty_d         = ty_q;
      yl_d         = yl_q;
      tex_d        = tex_q;
      tex0_d       = tex0_q;
      tex1_d       = tex1_q;
      pal_d        = pal_q;
      pend_d       = pend_q;
      rd_req       = 1'b0;
      rd_addr      = 13'd0;
      load_en      = 1'b0;
      load_px      = {tex0_q, tex1_q};
      load_pal     = pal_q;
      tile_advance = 1'b0;

      unique case (state_q)
         MAP:     rd_addr = {2'b10, tx_q, ty_q};
         TEX0:    rd_addr = {1'b0, tex_q, yl_q, 1'b0};
         TEX1:    rd_addr = {1'b0, tex_q, yl_q, 1'b1};
         PAL:     rd_addr = {3'b111, tx_q, ty_q[4:1]};
         default: rd_addr = 13'd0;
      endcase

      unique case (state_q)
         MAP, TEX0, TEX1, PAL: begin
            if (pend_q) begin
               // Data cycle: no new request while the single read completes.
               pend_d = 1'b0;
               unique case (state_q)
                  MAP: begin
                     tex_d   = rd_data;
                     state_d = TEX0;
                  end
                  TEX0: begin
                     tex0_d  = rd_data;
                     state_d = TEX1;
                  end
                  TEX1: begin
                     tex1_d  = rd_data;
                     state_d = PAL;
                  end
                  default: begin
                     // The palette byte goes straight into a free back buffer so
                     // a tile costs exactly four reads; otherwise park in LOAD.
                     pal_d = pal_nib;
                     if (!back_full_q) begin
                        load_en      = 1'b1;
                        load_pal     = pal_nib;
                        tile_advance = 1'b1;
                     end else begin
                        state_d = LOAD;
                     end
                  end
               endcase
            end else begin
               rd_req = 1'b1;
               if (rd_gnt) begin
                  pend_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (!back_full_q) begin
               load_en      = 1'b1;
               tile_advance = 1'b1;
            end
         end
         default: begin
         end
      endcase

      if (tile_advance) begin
         if (tx_q == LAST_TX) begin
            tx_d    = 6'd0;
            state_d = IDLE;
         end else begin
            tx_d    = tx_q + 6'd1;
            state_d = MAP;
         end
      end

      // A new line always wins: drop any read in flight and restart at tile 0.
      if (line_start) begin
         rd_req  = 1'b0;
         pend_d  = 1'b0;
         load_en = 1'b0;
         tx_d    = 6'd0;
         ty_d    = line_y[7:3];
         yl_d    = line_y[2:0];
         state_d = MAP;
      end
   end

   // Pixel buffers and line bookkeeping: drain the front, refill it from the back without a bubble, count pixels to find the line end.
   always_comb begin
      front_px_d  = front_px_q;
      front_pal_d = front_pal_q;
      front_cnt_d = front_cnt_q;
      back_px_d   = back_px_q;
      back_pal_d  = back_pal_q;
      back_full_d = back_full_q;
      pix_cnt_d   = pix_cnt_q;
      busy_d      = busy_q;
      line_done_d = 1'b0;

      if (accept) begin
         front_px_d  = {front_px_q[13:0], 2'b00};
         front_cnt_d = front_cnt_q - 4'd1;
         pix_cnt_d   = pix_cnt_q + 10'd1;
         if (pix_cnt_q == LAST_PIX) begin
            line_done_d = 1'b1;
         end
      end

      if (back_full_q && ((front_cnt_q == 4'd0) || (accept && (front_cnt_q == 4'd1)))) begin
         front_px_d  = back_px_q;
         front_pal_d = back_pal_q;
         front_cnt_d = 4'd8;
         back_full_d = 1'b0;
      end

      if (load_en) begin
         back_px_d   = load_px;
         back_pal_d  = load_pal;
         back_full_d = 1'b1;
      end

      if (line_done_q) begin
         busy_d = 1'b0;
      end

      if (line_start) begin
         front_cnt_d = 4'd0;
         back_full_d = 1'b0;
         pix_cnt_d   = 10'd0;
         line_done_d = 1'b0;
         busy_d      = 1'b1;
      end
   end

   // State register for the fetcher and the output buffers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         tx_q        <= 6'd0;
         ty_q        <= 5'd0;
         yl_q        <= 3'd0;
         tex_q       <= 8'd0;
         tex0_q      <= 8'd0;
         tex1_q      <= 8'd0;
         pal_q       <= 4'd0;
         pend_q      <= 1'b0;
         front_px_q  <= 16'd0;
         front_pal_q <= 4'd0;
         front_cnt_q <= 4'd0;
         back_px_q   <= 16'd0;
         back_pal_q  <= 4'd0;
         back_full_q <= 1'b0;
         pix_cnt_q   <= 10'd0;
         busy_q      <= 1'b0;
         line_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         ty_q        <= ty_d;
         yl_q        <= yl_d;
         tex_q       <= tex_d;
         tex0_q      <= tex0_d;
         tex1_q      <= tex1_d;
         pal_q       <= pal_d;
         pend_q      <= pend_d;
         front_px_q  <= front_px_d;
         front_pal_q <= front_pal_d;
         front_cnt_q <= front_cnt_d;
         back_px_q   <= back_px_d;
         back_pal_q  <= back_pal_d;
         back_full_q <= back_full_d;
         pix_cnt_q   <= pix_cnt_d;
         busy_q      <= busy_d;
         line_done_q <= line_done_d;
      end
   end

endmodule

// File: tb/tb_bcg_line_fetcher.sv
// tb_bcg_line_fetcher: directed scenarios against a VRAM model, with a
// line-level reference model (expected reads and pixel stream per scanline)
// checked every cycle, plus literal expectations for a hand-built tile.
module tb_bcg_line_fetcher;

   localparam int TILES    = 64;
   localparam int LINE_PIX = 8 * TILES;

   logic        clk;
   logic        rst;
   logic        line_start;
   logic [7:0]  line_y;
   logic        rd_req;
   logic [12:0] rd_addr;
   logic        rd_gnt;
   logic [7:0]  rd_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [5:0]  pix_col;
   logic        busy;
   logic        line_done;

   logic [7:0]  vram [0:8191];
   logic [5:0]  exp_pix [$];
   logic [12:0] exp_addr [$];
   logic [12:0] issued_log [$];
   logic [5:0]  pix_log [$];

   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          acc_line = 0;
   logic        gnt_mode = 1'b0;
   logic        gap_chk = 1'b0;

   logic [12:0] lit_addr [4] = '{13'h1002, 13'h0056, 13'h0057, 13'h1C01};
   logic [5:0]  lit_pix  [8] = '{6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2B, 6'h2A, 6'h29, 6'h28};

   bcg_line_fetcher #(.TILES(TILES)) dut (
      .clk        (clk),
      .rst        (rst),
      .line_start (line_start),
      .line_y     (line_y),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_gnt     (rd_gnt),
      .rd_data    (rd_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_col    (pix_col),
      .busy       (busy),
      .line_done  (line_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: bound expired before the awaited event", name);
   endtask

   // Reference: every read and every pixel a scanline must produce, straight from the address map.
   task automatic buildLine(input logic [7:0] y);
      logic [4:0]  ty;
      logic [2:0]  yl;
      logic [12:0] a_map, a0, a1, a_pal;
      logic [7:0]  tex, pal_byte;
      logic [15:0] px;
      logic [3:0]  nib;
      exp_pix.delete();
      exp_addr.delete();
      ty = y[7:3];
      yl = y[2:0];
      for (int tx = 0; tx < TILES; tx++) begin
         a_map    = {2'b10, 6'(tx), ty};
         tex      = vram[a_map];
         a0       = {1'b0, tex, yl, 1'b0};
         a1       = {1'b0, tex, yl, 1'b1};
         a_pal    = {3'b111, 6'(tx), ty[4:1]};
         pal_byte = vram[a_pal];
         nib      = ty[0] ? pal_byte[3:0] : pal_byte[7:4];
         px       = {vram[a0], vram[a1]};
         exp_addr.push_back(a_map);
         exp_addr.push_back(a0);
         exp_addr.push_back(a1);
         exp_addr.push_back(a_pal);
         for (int p = 0; p < 8; p++) begin
            exp_pix.push_back({nib, px[15 - 2 * p -: 2]});
         end
      end
   endtask

   task automatic applyStimulus(input logic [7:0] y);
      @(posedge clk); #1;
      line_y     = y;
      line_start = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
   endtask

   task automatic waitLineDone(input int bound);
      int  base;
      bit  seen;
      base = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(posedge clk); #1;
         if (done_cnt != base) seen = 1'b1;
      end
      if (!seen) reportTimeout("line_done_wait");
   endtask

   task automatic waitAccepted(input int n, input int bound);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(posedge clk); #1;
         if (acc_line >= n) seen = 1'b1;
      end
      if (!seen) reportTimeout("pixel_count_wait");
   endtask

   task automatic checkFirstTile(input string tag);
      if (issued_log.size() < 4) begin
         checkOutput({tag, "_read_count"}, 32'(issued_log.size()), 32'd4);
      end else begin
         for (int i = 0; i < 4; i++) checkOutput({tag, "_addr"}, 32'(issued_log[i]), 32'(lit_addr[i]));
      end
      if (pix_log.size() < 8) begin
         checkOutput({tag, "_pix_count"}, 32'(pix_log.size()), 32'd8);
      end else begin
         for (int i = 0; i < 8; i++) checkOutput({tag, "_pix"}, 32'(pix_log[i]), 32'(lit_pix[i]));
      end
   endtask

   // VRAM port: data for an issued read appears for exactly the next cycle, noise otherwise.
   initial begin : vram_port
      logic        issue;
      logic [12:0] a;
      rd_data = 8'h00;
      forever begin
         @(negedge clk);
         issue = rd_req && rd_gnt && !rst;
         a     = rd_addr;
         @(posedge clk); #1;
         rd_data = issue ? vram[a] : 8'($urandom);
      end
   end

   // Grant source: always granted, or alternating every cycle.
   initial begin : gnt_drive
      rd_gnt = 1'b0;
      forever begin
         @(posedge clk); #1;
         rd_gnt = gnt_mode ? ~rd_gnt : 1'b1;
      end
   end

   // Per-cycle compare of every output against the line model.
   initial begin : compare_proc
      logic        exp_done, exp_busy, cur_done, line_live;
      logic        flush_pend, hold_pend, addr_pend, acc;
      logic [5:0]  hold_col;
      logic [12:0] held_addr;
      exp_done = 0; exp_busy = 0; line_live = 0;
      flush_pend = 0; hold_pend = 0; addr_pend = 0;
      hold_col = '0; held_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_pix.delete();
            exp_addr.delete();
            acc_line   = 0;
            exp_done   = 0;
            exp_busy   = 0;
            line_live  = 0;
            flush_pend = 0;
            hold_pend  = 0;
            addr_pend  = 0;
         end else begin
            checkOutput("line_done", 32'(line_done), 32'(exp_done));
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            if (line_done) done_cnt++;
            if (flush_pend) checkOutput("flush_valid", 32'(pix_valid), 32'd0);
            if (hold_pend) begin
               checkOutput("hold_valid", 32'(pix_valid), 32'd1);
               checkOutput("hold_col", 32'(pix_col), 32'(hold_col));
            end
            if (addr_pend && !line_start) begin
               checkOutput("hold_req", 32'(rd_req), 32'd1);
               checkOutput("hold_addr", 32'(rd_addr), 32'(held_addr));
            end
            if (gap_chk && line_live && acc_line >= 8 && acc_line < LINE_PIX)
               checkOutput("no_gap_valid", 32'(pix_valid), 32'd1);
            if (rd_req && rd_gnt) begin
               issued_log.push_back(rd_addr);
               if (exp_addr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_read: got addr 0x%0h, required no read", rd_addr);
               end else begin
                  checkOutput("read_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
               end
            end
            acc = pix_valid && pix_ready;
            if (acc) begin
               pix_log.push_back(pix_col);
               if (exp_pix.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_pixel: got 0x%0h, required no pixel", pix_col);
               end else begin
                  checkOutput("pix_col", 32'(pix_col), 32'(exp_pix.pop_front()));
               end
               acc_line++;
            end
            cur_done   = exp_done;
            exp_done   = acc && line_live && (acc_line == LINE_PIX) && !line_start;
            if (exp_done) line_live = 0;
            exp_busy   = line_start ? 1'b1 : (cur_done ? 1'b0 : exp_busy);
            flush_pend = line_start;
            hold_pend  = pix_valid && !pix_ready && !line_start;
            hold_col   = pix_col;
            addr_pend  = rd_req && !rd_gnt && !line_start;
            held_addr  = rd_addr;
            if (line_start) begin
               buildLine(line_y);
               acc_line  = 0;
               line_live = 1;
               exp_done  = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int done_base;
      rst        = 1'b1;
      line_start = 1'b0;
      line_y     = 8'h00;
      pix_ready  = 1'b1;
      for (int i = 0; i < 8192; i++) vram[i] = 8'((i * 37) ^ (i >> 4));
      vram[13'h1002] = 8'h05;
      vram[13'h0056] = 8'h1B;
      vram[13'h0057] = 8'hE4;
      vram[13'h1C01] = 8'hA7;

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_rd_req", 32'(rd_req), 32'd0);
      checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
      checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
      checkOutput("rst_pix_col", 32'(pix_col), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_line_done", 32'(line_done), 32'd0);
      rst = 1'b0;

      $display("[TB] known tile and full line, grant always high");
      gap_chk = 1'b1;
      issued_log.delete();
      pix_log.delete();
      done_base = done_cnt;
      applyStimulus(8'h13);
      waitLineDone(4000);
      gap_chk = 1'b0;
      checkFirstTile("s2");
      checkOutput("s3_done_pulses", 32'(done_cnt - done_base), 32'd1);
      checkOutput("s3_pixels", 32'(pix_log.size()), 32'(LINE_PIX));
      repeat (2) @(posedge clk);
      #1;
      checkOutput("s3_busy_after", 32'(busy), 32'd0);

      $display("[TB] same line with grant toggling");
      gnt_mode = 1'b1;
      issued_log.delete();
      pix_log.delete();
      applyStimulus(8'h13);
      waitLineDone(6000);
      checkFirstTile("s4");
      checkOutput("s4_pixels", 32'(pix_log.size()), 32'(LINE_PIX));
      gnt_mode = 1'b0;

      $display("[TB] downstream stall mid-tile");
      pix_log.delete();
      applyStimulus(8'h2A);
      waitAccepted(13, 400);
      pix_ready = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("s5_fetch_parked", 32'(rd_req), 32'd0);
      checkOutput("s5_valid_held", 32'(pix_valid), 32'd1);
      pix_ready = 1'b1;
      waitLineDone(4000);
      checkOutput("s5_pixels", 32'(pix_log.size()), 32'(LINE_PIX));

      $display("[TB] abort with a read outstanding");
      done_base = done_cnt;
      applyStimulus(8'h55);
      waitAccepted(100, 400);
      begin : find_issue
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rd_req && rd_gnt) seen = 1'b1;
         end
         if (!seen) reportTimeout("s6_issue_wait");
      end
      issued_log.delete();
      applyStimulus(8'h7E);
      checkOutput("s6_flushed", 32'(pix_valid), 32'd0);
      waitLineDone(4000);
      if (issued_log.size() == 0) checkOutput("s6_read_count", 32'd0, 32'd1);
      else checkOutput("s6_first_addr", 32'(issued_log[0]), 32'h100F);
      checkOutput("s6_done_pulses", 32'(done_cnt - done_base), 32'd1);

      $display("[TB] reset mid-line");
      applyStimulus(8'h13);
      waitAccepted(20, 400);
      checkOutput("s1_valid_before", 32'(pix_valid), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("s1_rd_req", 32'(rd_req), 32'd0);
      checkOutput("s1_rd_addr", 32'(rd_addr), 32'd0);
      checkOutput("s1_pix_valid", 32'(pix_valid), 32'd0);
      checkOutput("s1_pix_col", 32'(pix_col), 32'd0);
      checkOutput("s1_busy", 32'(busy), 32'd0);
      checkOutput("s1_line_done", 32'(line_done), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      issued_log.delete();
      pix_log.delete();
      applyStimulus(8'h13);
      waitLineDone(4000);
      checkFirstTile("s1");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
